// File: rtl/tx_frame_arbiter.sv
// Round-robin frame arbiter in front of the UDP generator's byte-wide AXIS input.
// A source owns the bus from grant until its TX_EN burst and inter-frame gap have completed.
module tx_frame_arbiter #(
   parameter int NUM_SRC    = 4,
   parameter int LEN_W      = 12,
   parameter int MAX_LEN    = 1472,
   parameter int IFG_CYCLES = 48,
   parameter int TX_TIMEOUT = 65535
) (
   input  logic                     CLK,
   input  logic                     RST_N,
   input  logic [8*NUM_SRC-1:0]     S_AXIS_TDATA,
   input  logic [NUM_SRC-1:0]       S_AXIS_TVALID,
   input  logic [NUM_SRC-1:0]       S_AXIS_TLAST,
   input  logic [LEN_W*NUM_SRC-1:0] S_AXIS_TUSER,
   output logic [NUM_SRC-1:0]       S_AXIS_TREADY,
   output logic [7:0]               M_AXIS_TDATA,
   output logic                     M_AXIS_TVALID,
   output logic                     M_AXIS_TLAST,
   output logic [LEN_W-1:0]         M_AXIS_TUSER,
   input  logic                     M_AXIS_TREADY,
   input  logic                     TX_EN,
   output logic [NUM_SRC-1:0]       GRANT,
   output logic                     FRAME_DONE,
   output logic                     LEN_ERR,
   output logic                     TX_ERR
);
   localparam int IW     = $clog2(NUM_SRC);
   localparam int TW_TO  = $clog2(TX_TIMEOUT + 1);
   localparam int TW_IFG = $clog2(IFG_CYCLES + 1);
   localparam int TW     = (TW_TO > TW_IFG) ? TW_TO : TW_IFG;

   typedef enum logic [2:0] {ARB, XFER, PAD, DRAIN, WAIT_TX, GAP} state_t;

   state_t             state_q, state_d;
   logic [NUM_SRC-1:0] grant_q, grant_d;
   logic [IW-1:0]      gidx_q, gidx_d;
   logic [IW-1:0]      rr_q, rr_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic [LEN_W-1:0]   cnt_q, cnt_d;
   logic [TW-1:0]      tmr_q, tmr_d;
   logic               seen_q, seen_d;
   logic               to_gap_q, to_gap_d;
   logic               len_err_q, len_err_d;
   logic               tx_err_q, tx_err_d;
   logic               done_q, done_d;

   // Rotate requests so bit 0 is the source at the round-robin pointer.
   logic [2*NUM_SRC-1:0] req2;
   logic                 win_found;
   logic [IW-1:0]        win_off, win_idx;
   logic [IW:0]          win_sum;
   logic [LEN_W-1:0]     win_len;

   assign req2 = {S_AXIS_TVALID, S_AXIS_TVALID} >> rr_q;

   always_comb begin
      win_found = 1'b0;
      win_off   = '0;
      for (int k = NUM_SRC - 1; k >= 0; k--) begin
         if (req2[k]) begin
            win_found = 1'b1;
            win_off   = IW'(k);
         end
      end
   end

   assign win_sum = {1'b0, rr_q} + {1'b0, win_off};
   assign win_idx = (win_sum >= (IW+1)'(NUM_SRC)) ? IW'(win_sum - (IW+1)'(NUM_SRC)) : IW'(win_sum);
   assign win_len = S_AXIS_TUSER[win_idx*LEN_W +: LEN_W];

   logic [7:0] src_data;
   logic       src_valid, src_last, last_byte;

   assign src_data  = S_AXIS_TDATA[gidx_q*8 +: 8];
   assign src_valid = S_AXIS_TVALID[gidx_q];
   assign src_last  = S_AXIS_TLAST[gidx_q];
   assign last_byte = (cnt_q == len_q - LEN_W'(1));

   always_comb begin
      state_d       = state_q;
      grant_d       = grant_q;
      gidx_d        = gidx_q;
      rr_d          = rr_q;
      len_d         = len_q;
      cnt_d         = cnt_q;
      tmr_d         = tmr_q;
      seen_d        = seen_q;
      to_gap_d      = to_gap_q;
      len_err_d     = 1'b0;
      tx_err_d      = 1'b0;
      done_d        = 1'b0;
      S_AXIS_TREADY = '0;
      M_AXIS_TDATA  = '0;
      M_AXIS_TVALID = 1'b0;
      M_AXIS_TLAST  = 1'b0;
      case (state_q)
         ARB: begin
            if (win_found) begin
               grant_d = NUM_SRC'(1) << win_idx;
               gidx_d  = win_idx;
               len_d   = win_len;
               cnt_d   = '0;
               if (win_len == '0 || win_len > LEN_W'(MAX_LEN)) begin
                  len_err_d = 1'b1;
                  to_gap_d  = 1'b1;
                  state_d   = DRAIN;
               end else begin
                  state_d = XFER;
               end
            end
         end
         XFER: begin
            M_AXIS_TDATA  = src_data;
            M_AXIS_TVALID = src_valid;
            M_AXIS_TLAST  = last_byte;
            S_AXIS_TREADY = grant_q & {NUM_SRC{M_AXIS_TREADY}};
            if (src_valid && M_AXIS_TREADY) begin
               cnt_d = cnt_q + LEN_W'(1);
               if (last_byte) begin
                  if (src_last) begin
                     tmr_d   = '0;
                     seen_d  = 1'b0;
                     state_d = WAIT_TX;
                  end else begin
                     len_err_d = 1'b1;
                     to_gap_d  = 1'b0;
                     state_d   = DRAIN;
                  end
               end else if (src_last) begin
                  len_err_d = 1'b1;
                  state_d   = PAD;
               end
            end
         end
         PAD: begin
            M_AXIS_TVALID = 1'b1;
            M_AXIS_TLAST  = last_byte;
            if (M_AXIS_TREADY) begin
               cnt_d = cnt_q + LEN_W'(1);
               if (last_byte) begin
                  tmr_d   = '0;
                  seen_d  = 1'b0;
                  state_d = WAIT_TX;
               end
            end
         end
         DRAIN: begin
            S_AXIS_TREADY = grant_q;
            if (src_valid && src_last) begin
               tmr_d   = '0;
               seen_d  = 1'b0;
               state_d = to_gap_q ? GAP : WAIT_TX;
            end
         end
         WAIT_TX: begin
            if (!seen_q) begin
               if (TX_EN) begin
                  seen_d = 1'b1;
               end else if (tmr_q == TW'(TX_TIMEOUT - 1)) begin
                  tx_err_d = 1'b1;
                  tmr_d    = '0;
                  state_d  = GAP;
               end else begin
                  tmr_d = tmr_q + TW'(1);
               end
            end else if (!TX_EN) begin
               // The cycle that sees TX_EN fall is already the first idle cycle.
               tmr_d   = TW'(1);
               state_d = GAP;
            end
         end
         GAP: begin
            if (TX_EN) begin
               tmr_d = '0;
            end else if (tmr_q >= TW'(IFG_CYCLES - 1)) begin
               done_d  = 1'b1;
               grant_d = '0;
               rr_d    = (gidx_q == IW'(NUM_SRC - 1)) ? '0 : gidx_q + IW'(1);
               state_d = ARB;
            end else begin
               tmr_d = tmr_q + TW'(1);
            end
         end
         default: state_d = ARB;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_q   <= ARB;
         grant_q   <= '0;
         gidx_q    <= '0;
         rr_q      <= '0;
         len_q     <= '0;
         cnt_q     <= '0;
         tmr_q     <= '0;
         seen_q    <= 1'b0;
         to_gap_q  <= 1'b0;
         len_err_q <= 1'b0;
         tx_err_q  <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         gidx_q    <= gidx_d;
         rr_q      <= rr_d;
         len_q     <= len_d;
         cnt_q     <= cnt_d;
         tmr_q     <= tmr_d;
         seen_q    <= seen_d;
         to_gap_q  <= to_gap_d;
         len_err_q <= len_err_d;
         tx_err_q  <= tx_err_d;
         done_q    <= done_d;
      end
   end

   assign GRANT        = grant_q;
   assign M_AXIS_TUSER = len_q;
   assign LEN_ERR      = len_err_q;
   assign TX_ERR       = tx_err_q;
   assign FRAME_DONE   = done_q;

endmodule

// File: doc/tx_frame_arbiter.md
# tx_frame_arbiter

Frame-level scheduler in front of the UDP packet generator. Shares the single byte-wide AXIS input of the generator between NUM_SRC requesters using round-robin at frame boundaries. Presents a stable frame length on M_AXIS_TUSER for the whole frame, including the serialization that follows it. Enforces length correctness, then waits for the generator's TX_EN burst to finish and an inter-frame gap to elapse before granting the next frame.

## Interface
- NUM_SRC, 4: number of requesting sources (2..8).
- LEN_W, 12: width of frame length fields.
- MAX_LEN, 1472: largest legal payload length in bytes.
- IFG_CYCLES, 48: idle CLK cycles after TX_EN falls (12 bytes at 2 bits/cycle).
- TX_TIMEOUT, 65535: cycles to wait for TX_EN to rise before abandoning the frame.
- CLK  in  1  single clock; all logic on its rising edge.
- RST_N  in  1  reset, synchronous, active-low.
- S_AXIS_TDATA  in  8*NUM_SRC  per-source payload bytes; source i occupies bits [8i+7:8i].
- S_AXIS_TVALID  in  NUM_SRC  per-source valid; also acts as the frame request.
- S_AXIS_TLAST  in  NUM_SRC  per-source last-byte marker.
- S_AXIS_TUSER  in  LEN_W*NUM_SRC  per-source payload length; must be valid with the first byte.
- S_AXIS_TREADY  out  NUM_SRC  per-source ready.
- M_AXIS_TDATA  out  8  payload byte to the generator.
- M_AXIS_TVALID  out  1  master valid.
- M_AXIS_TLAST  out  1  generated last-byte marker.
- M_AXIS_TUSER  out  LEN_W  latched length of the current frame.
- M_AXIS_TREADY  in  1  generator ready.
- TX_EN  in  1  TX_EN from the generator's RMII output.
- GRANT  out  NUM_SRC  one-hot index of the current owner; 0 when no source owns the bus.
- FRAME_DONE  out  1  one-cycle pulse when a frame's gap completes.
- LEN_ERR  out  1  one-cycle pulse on any length violation.
- TX_ERR  out  1  one-cycle pulse on a TX_EN timeout.

## Operation
- **States:** ARB, XFER, PAD, DRAIN, WAIT_TX, GAP.
- **ARB:**
  - Scan TVALID round-robin, starting at the source after the last winner. After reset, source 0 has top priority.
  - On a winner: register GRANT, latch that source's TUSER into len_reg, clear byte_cnt.
  - If the length is 0 or greater than MAX_LEN: pulse LEN_ERR and go to DRAIN. Otherwise go to XFER.
  - With no requests, stay in ARB.
- **XFER:**
  - Data path: M_TDATA and M_TVALID = granted source; S_TREADY[g] = M_TREADY; all other S_TREADY = 0.
  - Each transfer (M_TVALID & M_TREADY) increments byte_cnt.
  - M_TLAST = (byte_cnt == len_reg-1) and is never forwarded from the source.
  - Last byte carries source TLAST: go to WAIT_TX.
  - Last byte has no source TLAST: pulse LEN_ERR, go to DRAIN.
  - Source TLAST arrives before the last byte: pulse LEN_ERR, go to PAD.
- **PAD:**
  - M_TVALID = 1, M_TDATA = 8'h00, S_TREADY = 0.
  - Count bytes until len_reg bytes total, asserting M_TLAST on the final pad byte, then go to WAIT_TX.
- **DRAIN:**
  - S_TREADY[g] = 1, M_TVALID = 0. Discard bytes until source TLAST is accepted.
  - After a length error detected in ARB: go to GAP with no TX wait.
  - After an overrun from XFER: go to WAIT_TX.
- **WAIT_TX:**
  - Wait for TX_EN to rise, then fall, then go to GAP.
  - If TX_EN has not risen within TX_TIMEOUT cycles of entry: pulse TX_ERR and go to GAP.
- **GAP:**
  - Count IFG_CYCLES cycles with TX_EN low. If TX_EN goes high during GAP, restart the count.
  - At the end: pulse FRAME_DONE, clear GRANT, advance the round-robin pointer past the winner, go to ARB.
- **Arithmetic:** byte_cnt is LEN_W bits. Comparisons are against len_reg-1, which is only evaluated when len_reg ≥ 1.

## Timing
- **Reset (RST_N low at a CLK edge):**
  - State ARB, rr pointer = 0.
  - All outputs 0, including M_AXIS_TUSER, GRANT, pulses and S_TREADY.
  - Counters cleared.
  - Reset mid-frame abandons the frame immediately and does not drain it.
- **Latency:** a TVALID seen in ARB at edge n sets GRANT and enters XFER at edge n+1. The first byte can transfer in the cycle after edge n+1.
- **Combinational path:** S_TREADY = f(state, GRANT, M_TREADY); no register.
- **Back-pressure:** M_TREADY low holds M_TDATA, M_TVALID and M_TLAST stable, AXIS-compliant.
- **TUSER hold:** M_AXIS_TUSER stays at len_reg from the ARB win through the end of GAP. The generator samples TUSER during serialization, so it must not change in that window.
- **Simultaneous requests:** a new TVALID on the current winner during GAP is not granted before the scan rotates past it.

## Test plan
- **Single frame:** source 0 with TUSER=4 sends 4 bytes, TLAST on the 4th; TX_EN high 200 cycles. Expect:
  - M_TDATA identical, M_TLAST on byte 4, M_TUSER=4 throughout;
  - FRAME_DONE exactly 48 cycles after TX_EN falls.
- **Round-robin:** sources 0, 1 and 3 all hold TVALID continuously. Expect grants in the order 0, 1, 3, 0, with no overlap and M_TUSER changing only in ARB.
- **Underrun:** TUSER=8 but TLAST on byte 5. Expect LEN_ERR pulse, 3 bytes of 8'h00, M_TLAST on byte 8.
- **Overrun:** TUSER=3 but 6 bytes sent. Expect LEN_ERR, M_TLAST on byte 3, bytes 4–6 consumed with M_TVALID low.
- **Illegal length:** TUSER=0, then TUSER=1500. Expect LEN_ERR each time, frames fully drained, M_TVALID never high, no wait for TX_EN.
- **TX_EN timeout and reset:** TX_EN held low after a frame; expect TX_ERR after 65535 cycles. Then drop RST_N mid-XFER; expect all outputs 0 on the next edge and source 0 granted first afterwards.
